// File: rtl/edge_bit_packer.sv
// edge_bit_packer
//   Thresholds a stream of binarized edge pixels into single bits, packs
//   eight of them (or fewer, when a line ends early) into a byte, and
//   queues the bytes in a small FIFO for a downstream consumer.
//
// Parameters
//   BIT_THRESHOLD : pixel >= threshold becomes bit 1, otherwise bit 0
//   FIFO_DEPTH    : packed-byte FIFO entries (power of two, >= 2)
//   LSB_FIRST     : 1 = first pixel of a byte lands in bit 0, 0 = bit 7
//   DATA_W        : pixel width
//
// Ports
//   i_clk        : clock, all state updates on the rising edge
//   i_rst        : synchronous active-high reset
//   i_valid      : input_pixel / i_eol valid this cycle
//   input_pixel  : binarized edge pixel (nominally 0 or 255)
//   i_eol        : pixel is the last one of its image line
//   o_ready      : block accepts a pixel this cycle (FIFO not full)
//   o_data       : packed byte at the FIFO head (8'h00 when empty)
//   o_last       : o_data is the final byte of a line
//   o_valid      : o_data / o_last valid (FIFO not empty)
//   i_ready      : downstream takes the head byte this cycle
module edge_bit_packer #(
  parameter int BIT_THRESHOLD = 128,
  parameter int FIFO_DEPTH    = 4,
  parameter bit LSB_FIRST     = 1'b1,
  parameter int DATA_W        = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] input_pixel,
  input  logic              i_eol,
  output logic              o_ready,
  output logic [7:0]        o_data,
  output logic              o_last,
  output logic              o_valid,
  input  logic              i_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int THR_W = DATA_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [THR_W-1:0] THR_C   = THR_W'(BIT_THRESHOLD);

  // One extra bit so thresholds above the pixel range simply never fire.
  function automatic logic binarize(input logic [DATA_W-1:0] px);
    return ({1'b0, px} >= THR_C);
  endfunction

  logic [2:0]       bit_cnt;
  logic [7:0]       acc;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] occ;
  logic [8:0]       fifo_mem [FIFO_DEPTH];

  logic       accept;
  logic       pop;
  logic       push;
  logic       pix_bit_p0;
  logic [2:0] bit_pos_p0;
  logic [7:0] acc_nxt_p0;

  // Handshake flags come only from the registered occupancy, so o_ready
  // has no combinational dependence on i_ready.
  assign o_ready = (occ < DEPTH_C);
  assign o_valid = (occ != '0);

  // Reset cycles neither accept pixels nor pop bytes.
  assign accept = i_valid && o_ready && !i_rst;
  assign pop    = o_valid && i_ready && !i_rst;

  // ---- stage p0: threshold the pixel and merge it into the accumulator
  assign pix_bit_p0 = binarize(input_pixel);
  assign bit_pos_p0 = LSB_FIRST ? bit_cnt : (3'd7 - bit_cnt);

  always_comb begin
    acc_nxt_p0             = acc;
    acc_nxt_p0[bit_pos_p0] = pix_bit_p0;
  end

  // A byte closes on its eighth bit or at end of line; positions not yet
  // written are still zero because the accumulator clears on every push.
  assign push = accept && ((bit_cnt == 3'd7) || i_eol);

  // ---- stage p1: packer state and FIFO bookkeeping
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bit_cnt <= 3'd0;
      acc     <= 8'h00;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
    end else begin
      if (push) begin
        bit_cnt <= 3'd0;
        acc     <= 8'h00;
      end else if (accept) begin
        bit_cnt <= bit_cnt + 3'd1;
        acc     <= acc_nxt_p0;
      end

      // Power-of-two depth lets the pointers wrap naturally.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage is data only; an empty FIFO is masked at the output instead.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr] <= {i_eol, acc_nxt_p0};
  end

  // ---- stage p2: FIFO head presentation
  assign o_data = o_valid ? fifo_mem[rd_ptr][7:0] : 8'h00;
  assign o_last = o_valid && fifo_mem[rd_ptr][8];

endmodule

// File: tb/tb_edge_bit_packer.sv
module tb_edge_bit_packer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld;
  logic [7:0] px;
  logic       eol;
  logic       rdy_in;

  logic       r_l, lst_l, v_l;
  logic [7:0] d_l;
  logic       r_m, lst_m, v_m;
  logic [7:0] d_m;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  edge_bit_packer #(.BIT_THRESHOLD(128), .FIFO_DEPTH(DEPTH), .LSB_FIRST(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(vld), .input_pixel(px), .i_eol(eol),
    .o_ready(r_l), .o_data(d_l), .o_last(lst_l), .o_valid(v_l), .i_ready(rdy_in)
  );

  edge_bit_packer #(.BIT_THRESHOLD(128), .FIFO_DEPTH(DEPTH), .LSB_FIRST(1'b0)) dut_msb (
    .i_clk(clk), .i_rst(rst), .i_valid(vld), .input_pixel(px), .i_eol(eol),
    .o_ready(r_m), .o_data(d_m), .o_last(lst_m), .o_valid(v_m), .i_ready(rdy_in)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Bytes are kept as a queue of {lsb-first byte, msb-first byte, last};
  // the partial byte is a list of the bits seen so far.
  typedef struct packed {
    logic [7:0] lsb;
    logic [7:0] msb;
    logic       last;
  } ent_t;

  ent_t       mq[$];
  bit         pbits[$];
  logic [8:0] mlog_l[$];
  logic [8:0] mlog_m[$];
  bit         armed = 1'b0;

  always @(posedge clk) begin
    bit   m_acc, m_pop;
    ent_t e;
    if (rst) begin
      mq.delete();
      pbits.delete();
      armed = 1'b1;
    end else if (armed) begin
      m_acc = vld && (mq.size() < DEPTH);
      m_pop = (mq.size() > 0) && rdy_in;
      if (m_pop) begin
        mlog_l.push_back({mq[0].last, mq[0].lsb});
        mlog_m.push_back({mq[0].last, mq[0].msb});
        void'(mq.pop_front());
      end
      if (m_acc) begin
        pbits.push_back(px >= 8'd128);
        if (pbits.size() == 8 || eol) begin
          e.lsb  = 8'h00;
          e.msb  = 8'h00;
          e.last = eol;
          for (int i = 0; i < pbits.size(); i++) begin
            e.lsb[i]     = pbits[i];
            e.msb[7 - i] = pbits[i];
          end
          mq.push_back(e);
          pbits.delete();
        end
      end
    end
  end

  // ---------------- per-cycle compare and pop log ----------------
  logic [8:0] log_l[$];
  logic [8:0] log_m[$];

  always @(negedge clk) begin
    logic       ev, er, el_l, el_m;
    logic [7:0] ed_l, ed_m;
    if (armed) begin
      ev = (mq.size() > 0);
      er = (mq.size() < DEPTH);
      ed_l = 8'h00; ed_m = 8'h00; el_l = 1'b0; el_m = 1'b0;
      if (ev) begin
        ed_l = mq[0].lsb; ed_m = mq[0].msb;
        el_l = mq[0].last; el_m = mq[0].last;
      end
      chk("ready_lsb", r_l, er);
      chk("valid_lsb", v_l, ev);
      chk("data_lsb", d_l, ed_l);
      chk("last_lsb", lst_l, el_l);
      chk("ready_msb", r_m, er);
      chk("valid_msb", v_m, ev);
      chk("data_msb", d_m, ed_m);
      chk("last_msb", lst_m, el_m);
      if (!rst && v_l && rdy_in) log_l.push_back({lst_l, d_l});
      if (!rst && v_m && rdy_in) log_m.push_back({lst_m, d_m});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Presents one pixel and holds it until accepted; leaves it presented.
  task automatic send(input logic [7:0] p, input logic e);
    int   n;
    logic took;
    px = p; eol = e; vld = 1'b1;
    n = 0; took = 1'b0;
    while (!took && n < 100) begin
      took = r_l;
      cyc();
      n++;
    end
    if (!took) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: got ready=0 for %0d cycles, expected acceptance", n);
    end
  endtask

  task automatic idle();
    vld = 1'b0; eol = 1'b0; px = 8'h00;
  endtask

  task automatic drain();
    int n;
    idle();
    rdy_in = 1'b1;
    n = 0;
    while (v_l && n < 20) begin cyc(); n++; end
    chk("drain_empty", v_l, 1'b0);
  endtask

  // Checks popped byte idx from both DUT logs and both model logs.
  task automatic chk_log(input string name, input int idx,
                         input logic [8:0] exp_l, input logic [8:0] exp_m);
    if (idx >= log_l.size() || idx >= log_m.size() ||
        idx >= mlog_l.size() || idx >= mlog_m.size()) begin
      n_checks++; n_fail++;
      $display("FAIL %s: byte %0d missing, got %0d bytes, expected more", name, idx, log_l.size());
    end else begin
      chk({name, "_dut_lsb"}, log_l[idx], exp_l);
      chk({name, "_dut_msb"}, log_m[idx], exp_m);
      chk({name, "_mdl_lsb"}, mlog_l[idx], exp_l);
      chk({name, "_mdl_msb"}, mlog_m[idx], exp_m);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    logic [7:0] pat [8];

    rst = 1'b1; vld = 1'b0; px = 8'h00; eol = 1'b0; rdy_in = 1'b0;
    cyc(); cyc();
    rst = 1'b0;

    // Reset state
    chk("reset_valid", v_l, 1'b0);
    chk("reset_ready", r_l, 1'b1);
    chk("reset_data", d_l, 8'h00);
    chk("reset_last", lst_l, 1'b0);

    // Basic packing: 255,0,255,0,0,0,0,255 -> 0x85 (msb-first 0xA1)
    rdy_in = 1'b1;
    base = log_l.size();
    pat = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255};
    for (int i = 0; i < 8; i++) begin
      send(pat[i], 1'b0);
      if (i < 7) chk("pack_not_yet_valid", v_l, 1'b0);
    end
    idle();
    chk("pack_valid_after_8th", v_l, 1'b1);
    chk("pack_data_after_8th", d_l, 8'h85);
    drain();
    chk_log("pack85", base, 9'h085, 9'h0A1);

    // Early end of line: 255,255,255(eol) -> 0x07 last; next pixel at bit 0
    base = log_l.size();
    send(8'd255, 1'b0);
    send(8'd255, 1'b0);
    send(8'd255, 1'b1);
    send(8'd255, 1'b1);
    idle();
    drain();
    chk_log("eol3", base, 9'h107, 9'h1E0);
    chk_log("eol_restart", base + 1, 9'h101, 9'h180);

    // Backpressure: 40 pixels of 255, downstream stalled
    base = log_l.size();
    rdy_in = 1'b0;
    for (int i = 0; i < 32; i++) send(8'd255, 1'b0);
    chk("full_ready_low", r_l, 1'b0);
    chk("full_valid", v_l, 1'b1);
    cyc(); cyc(); cyc();
    chk("full_ready_held", r_l, 1'b0);
    rdy_in = 1'b1;
    for (int i = 0; i < 8; i++) send(8'd255, 1'b0);
    idle();
    drain();
    chk("full_byte_count", log_l.size() - base, 5);
    for (int i = 0; i < 5; i++) chk_log("full_ff", base + i, 9'h0FF, 9'h0FF);

    // Push coinciding with pop at occupancy 2
    base = log_l.size();
    rdy_in = 1'b0;
    pat = '{8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    for (int i = 0; i < 8; i++) send(pat[i], 1'b0);
    pat = '{8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    for (int i = 0; i < 8; i++) send(pat[i], 1'b0);
    pat = '{8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    for (int i = 0; i < 7; i++) send(pat[i], 1'b0);
    rdy_in = 1'b1;
    send(pat[7], 1'b0);
    rdy_in = 1'b0;
    idle();
    chk("occ2_valid", v_l, 1'b1);
    rdy_in = 1'b1;
    cyc(); cyc();
    chk("occ2_empty_after_two_pops", v_l, 1'b0);
    drain();
    chk_log("order_a", base, 9'h001, 9'h080);
    chk_log("order_b", base + 1, 9'h002, 9'h040);
    chk_log("order_c", base + 2, 9'h003, 9'h0C0);

    // Reset mid-stream: 2 bytes queued plus 5 pixels in the packer
    rdy_in = 1'b0;
    for (int i = 0; i < 21; i++) send(8'd255, 1'b0);
    rst = 1'b1; vld = 1'b1; px = 8'd255;
    cyc();
    rst = 1'b0;
    idle();
    chk("rst_valid", v_l, 1'b0);
    chk("rst_ready", r_l, 1'b1);
    chk("rst_data", d_l, 8'h00);
    base = log_l.size();
    rdy_in = 1'b1;
    for (int i = 0; i < 8; i++) send(8'd0, 1'b0);
    idle();
    cyc(); cyc();
    chk("rst_one_byte", log_l.size() - base, 1);
    chk_log("rst_zero", base, 9'h000, 9'h000);

    // Bit order and threshold boundary
    base = log_l.size();
    send(8'd255, 1'b0);
    for (int i = 0; i < 7; i++) send(8'd0, 1'b0);
    send(8'd127, 1'b0);
    send(8'd128, 1'b1);
    idle();
    drain();
    chk_log("msb80", base, 9'h001, 9'h080);
    chk_log("thresh", base + 1, 9'h102, 9'h140);

    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
